// File: rtl/tournament_selector.sv
// rtl/tournament_selector.sv - two-candidate tournament selector driving an external fitness unit
// SELECTOR_MINIMIZE_EN: when defined the smaller fitness wins; ties always go to cand_a.
module tournament_selector #(
  parameter int FF_LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [7:0]  cand_a,
  input  logic signed [7:0]  cand_b,
  output logic signed [7:0]  ff_chrom1,
  output logic signed [7:0]  ff_chrom2,
  output logic               ff_enable,
  input  logic signed [26:0] ff_fitness1,
  input  logic signed [26:0] ff_fitness2,
  output logic               win_valid,
  input  logic               win_ready,
  output logic signed [7:0]  win_chrom,
  output logic signed [26:0] win_fitness
);

  typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       last_eval;
  logic       slot2_wins;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Slot 2 only wins on a strict improvement, so ties keep cand_a.
`ifdef SELECTOR_MINIMIZE_EN
  assign slot2_wins = (ff_fitness2 < ff_fitness1);
`else
  assign slot2_wins = (ff_fitness2 > ff_fitness1);
`endif

  assign last_eval = (state == EVAL) && (cnt == 4'(FF_LATENCY - 1));

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ff_enable = 1'b0;
    win_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_nxt = EVAL;
      end
      EVAL: begin
        ff_enable = !rst;
        if (last_eval) state_nxt = OUT;
      end
      OUT: begin
        win_valid = !rst;
        if (win_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 4'd0;
      ff_chrom1   <= 8'sd0;
      ff_chrom2   <= 8'sd0;
      win_chrom   <= 8'sd0;
      win_fitness <= 27'sd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ff_chrom1 <= cand_a;
            ff_chrom2 <= cand_b;
            cnt       <= 4'd0;
          end
        end
        EVAL: begin
          cnt <= cnt + 4'd1;
          if (last_eval) begin
            win_chrom   <= slot2_wins ? ff_chrom2   : ff_chrom1;
            win_fitness <= slot2_wins ? ff_fitness2 : ff_fitness1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tournament_selector.sv
// tb/tb_tournament_selector.sv - randomized self-checking bench for tournament_selector
module tb_tournament_selector;

  localparam int LAT = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [7:0]  cand_a, cand_b;
  logic signed [7:0]  ff_chrom1, ff_chrom2;
  logic               ff_enable;
  logic signed [26:0] ff_fitness1, ff_fitness2;
  logic               win_valid;
  logic               win_ready;
  logic signed [7:0]  win_chrom;
  logic signed [26:0] win_fitness;

  int errors = 0;
  int checks = 0;

  // Fitness stub: true values only in the last enable cycle, junk otherwise.
  logic signed [26:0] fit1, fit2, junk1, junk2;
  int en_cnt = 0;

  tournament_selector #(.FF_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .cand_a(cand_a), .cand_b(cand_b),
    .ff_chrom1(ff_chrom1), .ff_chrom2(ff_chrom2), .ff_enable(ff_enable),
    .ff_fitness1(ff_fitness1), .ff_fitness2(ff_fitness2),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_chrom(win_chrom), .win_fitness(win_fitness)
  );

  always #5 clk = ~clk;

  always @(posedge clk) en_cnt <= ff_enable ? en_cnt + 1 : 0;

  assign ff_fitness1 = (ff_enable && en_cnt == LAT - 1) ? fit1 : junk1;
  assign ff_fitness2 = (ff_enable && en_cnt == LAT - 1) ? fit2 : junk2;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: which slot wins a tournament, from the selection rule alone.
  function automatic int pick_slot(input longint f1, input longint f2);
`ifdef SELECTOR_MINIMIZE_EN
    return (f2 < f1) ? 2 : 1;
`else
    return (f2 > f1) ? 2 : 1;
`endif
  endfunction

  task automatic do_tx(input logic signed [7:0] a, input logic signed [7:0] b,
                       input logic signed [26:0] f1, input logic signed [26:0] f2,
                       input int hold, input bit pester);
    int en_seen, win_cyc;
    longint exp_chrom, exp_fit;
    fit1  = f1;
    fit2  = f2;
    junk1 = 27'($urandom);
    junk2 = 27'($urandom);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    cand_a   = a;
    cand_b   = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = pester;
    cand_a   = 8'($urandom);
    cand_b   = 8'($urandom);
    en_seen  = 0;
    win_cyc  = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clk);
      if (ff_enable) begin
        en_seen++;
        check("ff_chrom1_stable", ff_chrom1, a);
        check("ff_chrom2_stable", ff_chrom2, b);
      end
      if (win_valid) begin
        win_cyc = c;
        break;
      end
    end
    check("ff_enable_cycles", en_seen, LAT);
    check("win_latency", win_cyc, LAT + 1);
    if (win_cyc == 0) return;
    exp_chrom = (pick_slot(f1, f2) == 2) ? longint'(b)  : longint'(a);
    exp_fit   = (pick_slot(f1, f2) == 2) ? longint'(f2) : longint'(f1);
    check("win_chrom", win_chrom, exp_chrom);
    check("win_fitness", win_fitness, exp_fit);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_win_valid", win_valid, 1);
      check("hold_win_chrom", win_chrom, exp_chrom);
      check("hold_win_fitness", win_fitness, exp_fit);
      check("hold_in_ready", in_ready, 0);
      check("hold_ff_enable", ff_enable, 0);
    end
    win_ready = 1'b1;
    @(negedge clk);
    win_ready = 1'b0;
    check("post_hs_win_valid", win_valid, 0);
    check("post_hs_in_ready", in_ready, 1);
    check("post_hs_no_accept", ff_enable, 0);
    in_valid = 1'b0;
  endtask

  initial begin
    logic signed [26:0] rf1, rf2;
    int quiet;
    rst = 1'b1; in_valid = 1'b0; win_ready = 1'b0;
    cand_a = '0; cand_b = '0;
    fit1 = '0; fit2 = '0; junk1 = '0; junk2 = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_ff_enable", ff_enable, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_win_chrom", win_chrom, 0);
    check("rst_win_fitness", win_fitness, 0);
    check("rst_ff_chrom1", ff_chrom1, 0);
    rst = 1'b0;
    @(negedge clk);
    check("release_in_ready", in_ready, 1);

    do_tx(8'sd5, -8'sd3, 27'sd100, -27'sd20, 0, 1'b0);
    do_tx(8'sd7, 8'sd9, 27'sd42, 27'sd42, 1, 1'b0);
    do_tx(8'sd1, 8'sd2, -27'sd5, -27'sd1, 0, 1'b0);
    do_tx(8'sd11, -8'sd128, 27'sh3FFFFFF, 27'sh4000000, 10, 1'b1);

    // Abort in the second EVAL cycle.
    fit1 = 27'sd1; fit2 = 27'sd2;
    @(negedge clk);
    cand_a = 8'sd3; cand_b = 8'sd4; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_eval1_enable", ff_enable, 1);
    @(negedge clk);
    check("abort_eval2_enable", ff_enable, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ff_enable", ff_enable, 0);
    check("abort_in_ready_in_rst", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready_after", in_ready, 1);
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (win_valid || ff_enable) quiet++;
    end
    check("abort_no_result", quiet, 0);

    for (int t = 0; t < 25; t++) begin
      rf1 = 27'($urandom);
      rf2 = ($urandom_range(0, 3) == 0) ? rf1 : 27'($urandom);
      do_tx(8'($urandom), 8'($urandom), rf1, rf2, $urandom_range(0, 3), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
